// File: rtl/be_ber_checker_if.sv
// Decision/expected stream bundle feeding the BER checker: DUT decision word
// plus the reference word, each with its own valid.
interface be_ber_checker_if #(
    parameter int LANES = 64
) ();
    logic [LANES-1:0] drx;
    logic             drx_vld;
    logic [LANES-1:0] exp;
    logic             exp_vld;

    modport master (output drx, drx_vld, exp, exp_vld);
    modport slave  (input  drx, drx_vld, exp, exp_vld);
endinterface

// File: rtl/be_ber_checker.sv
// In-silicon BER checker beside dsp_be: aligns the expected stream, skips pipeline
// fill, then counts checked words, bit errors and captures the first bad word.
module be_ber_checker #(
    parameter int LANES   = 64,
    parameter int DLY_MAX = 32,
    parameter int CNT_W   = 40,
    parameter int SKIP_W  = 8
) (
    input  logic                       i_clk_dig_be,
    input  logic                       i_rst_n,
    input  logic                       i_start,
    input  logic                       i_abort,
    input  logic                       i_stop_on_err,
    input  logic [$clog2(DLY_MAX)-1:0] i_dly,
    input  logic [SKIP_W-1:0]          i_skip,
    input  logic [CNT_W-1:0]           i_target,
    be_ber_checker_if.slave            bus,
    output logic                       o_busy,
    output logic                       o_done,
    output logic                       o_err_any,
    output logic [CNT_W-1:0]           o_err_cnt,
    output logic [CNT_W-1:0]           o_word_cnt,
    output logic [CNT_W-1:0]           o_first_err_idx,
    output logic [LANES-1:0]           o_first_err_xor
);
    localparam int DW   = $clog2(DLY_MAX);
    localparam int PC_W = $clog2(LANES + 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SKIP  = 3'd1;
    localparam logic [2:0] ST_CHECK = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    logic [2:0]                  state;
    logic [DLY_MAX-1:0][LANES:0] dline;
    logic [LANES:0]              exp_tap;
    logic                        cmp;
    logic                        hit_target;
    logic                        last_word;
    logic                        err_now;
    logic [LANES-1:0]            xor_now;
    logic                        s1_vld;
    logic [LANES-1:0]            s1_xor;
    logic [SKIP_W-1:0]           skip_cnt;
    logic [PC_W-1:0]             pc;
    logic [CNT_W:0]              err_sum;

    // dline[k] holds {exp_vld, exp} from k+1 cycles ago; i_dly=0 bypasses the line
    always_comb begin
        exp_tap = (i_dly == '0) ? {bus.exp_vld, bus.exp} : dline[i_dly - DW'(1)];
    end

    assign cmp        = bus.drx_vld & exp_tap[LANES];
    assign xor_now    = bus.drx ^ exp_tap[LANES-1:0];
    assign err_now    = |xor_now;
    assign hit_target = (o_word_cnt == i_target);
    assign last_word  = ((o_word_cnt + CNT_W'(1)) == i_target);

    always_comb begin
        pc = '0;
        for (int i = 0; i < LANES; i++) pc = pc + PC_W'(s1_xor[i]);
    end

    assign err_sum = {1'b0, o_err_cnt} + (CNT_W + 1)'(pc);

    always_ff @(posedge i_clk_dig_be) begin
        if (!i_rst_n) begin
            state           <= ST_IDLE;
            dline           <= '0;
            s1_vld          <= 1'b0;
            s1_xor          <= '0;
            skip_cnt        <= '0;
            o_err_any       <= 1'b0;
            o_err_cnt       <= '0;
            o_word_cnt      <= '0;
            o_first_err_idx <= '0;
            o_first_err_xor <= '0;
        end else begin
            dline  <= {dline[DLY_MAX-2:0], {bus.exp_vld, bus.exp}};
            s1_vld <= 1'b0;

            // Stage 2: stage 1 is absorbed every cycle, so the accumulator trails by one.
            // o_word_cnt already counts this word here, hence the -1 for its index.
            if (s1_vld) begin
                o_err_cnt <= err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
                if ((|s1_xor) && !o_err_any) begin
                    o_err_any       <= 1'b1;
                    o_first_err_idx <= o_word_cnt - CNT_W'(1);
                    o_first_err_xor <= s1_xor;
                end
            end

            if (i_abort) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE, ST_DONE: begin
                        if (i_start) begin
                            state           <= (i_skip == '0) ? ST_CHECK : ST_SKIP;
                            skip_cnt        <= '0;
                            o_err_any       <= 1'b0;
                            o_err_cnt       <= '0;
                            o_word_cnt      <= '0;
                            o_first_err_idx <= '0;
                            o_first_err_xor <= '0;
                        end
                    end
                    ST_SKIP: begin
                        if (cmp) begin
                            skip_cnt <= skip_cnt + SKIP_W'(1);
                            if ((skip_cnt + SKIP_W'(1)) == i_skip) state <= ST_CHECK;
                        end
                    end
                    ST_CHECK: begin
                        if (hit_target) begin
                            state <= ST_DRAIN;
                        end else if (cmp) begin
                            o_word_cnt <= o_word_cnt + CNT_W'(1);
                            s1_vld     <= 1'b1;
                            s1_xor     <= xor_now;
                            if (last_word || (i_stop_on_err && err_now)) state <= ST_DRAIN;
                        end
                    end
                    // the last stage-1 word lands in the accumulator on this edge
                    ST_DRAIN: state <= ST_DONE;
                    default:  state <= ST_IDLE;
                endcase
            end
        end
    end

    assign o_busy = (state == ST_SKIP) || (state == ST_CHECK) || (state == ST_DRAIN);
    assign o_done = (state == ST_DONE);
endmodule

// File: tb/tb_be_ber_checker.sv
// Randomized scoreboard bench for be_ber_checker: a cycle-walking reference model
// predicts each run's final results; a monitor checks them when o_done rises.
module tb_be_ber_checker;
    localparam int LANES   = 64;
    localparam int DLY_MAX = 32;
    localparam int CNT_W   = 12;
    localparam int SKIP_W  = 8;
    localparam int DW      = $clog2(DLY_MAX);
    localparam longint CMAX = (longint'(1) << CNT_W) - 1;

    typedef logic [LANES-1:0] word_t;
    typedef struct {
        logic [CNT_W-1:0] words;
        logic [CNT_W-1:0] errs;
        logic             any;
        logic [CNT_W-1:0] fidx;
        word_t            fxor;
        int unsigned      done_cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n, start, abort, stop;
    logic [DW-1:0]    dly;
    logic [SKIP_W-1:0] skip;
    logic [CNT_W-1:0] target;
    logic             busy, done, err_any;
    logic [CNT_W-1:0] err_cnt, word_cnt, first_idx;
    word_t            first_xor;

    be_ber_checker_if #(.LANES(LANES)) bus ();

    be_ber_checker #(.LANES(LANES), .DLY_MAX(DLY_MAX), .CNT_W(CNT_W), .SKIP_W(SKIP_W)) dut (
        .i_clk_dig_be(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort),
        .i_stop_on_err(stop), .i_dly(dly), .i_skip(skip), .i_target(target), .bus(bus),
        .o_busy(busy), .o_done(done), .o_err_any(err_any), .o_err_cnt(err_cnt),
        .o_word_cnt(word_cnt), .o_first_err_idx(first_idx), .o_first_err_xor(first_xor)
    );

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int    n_cmp = 0, n_fail = 0;
    exp_t  sb[$];
    word_t he[$];
    bit    hev[$];
    word_t inj_mask[int];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, req, cyc);
        end
    endtask

    // monitor: scoreboard pop on each rising o_done
    logic prev_done = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        chk("busy_done_exclusive", busy & done, 0);
        if (done && !prev_done) begin
            if (sb.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL unexpected_done: got done with empty scoreboard (cyc %0d)", cyc);
            end else begin
                e = sb.pop_front();
                chk("word_cnt",  word_cnt,  e.words);
                chk("err_cnt",   err_cnt,   e.errs);
                chk("err_any",   err_any,   e.any);
                chk("first_idx", first_idx, e.fidx);
                chk("first_xor", first_xor, e.fxor);
                chk("done_cyc",  cyc,       e.done_cyc);
            end
        end
        prev_done <= done;
    end

    task automatic drive(input bit st, input bit ab, input bit rn, input word_t d, input bit dv,
                         input word_t e, input bit ev);
        start = st; abort = ab; rst_n = rn;
        bus.drx = d; bus.drx_vld = dv; bus.exp = e; bus.exp_vld = ev;
        @(posedge clk); #1;
        if (!rn) begin he.delete(); hev.delete(); end
        else begin he.push_back(e); hev.push_back(ev); end
    endtask

    function automatic word_t inj(input int mode, input int w);
        word_t m = '0;
        case (mode)
            1: if (inj_mask.exists(w)) m = inj_mask[w];
            2: m = '1;
            3: if ($urandom_range(9) == 0) m = word_t'(1) << $urandom_range(LANES - 1);
            default: m = '0;
        endcase
        return m;
    endfunction

    // mode: 0 clean, 1 listed injections, 2 all-ones, 3 random flips.
    // ab_t / rst_t > 0: abort / reset in that plan cycle instead of finishing.
    task automatic run(input int d, input int sk, input int tgt, input bit so, input int vpct,
                       input int mode, input int ab_t, input int rst_t);
        int h, T, words, fidx, skc, dec_t, stop_t, last;
        longint errs;
        bit any, chk_ph;
        word_t fxor;
        word_t pe[], pd[];
        bit pev[], pdv[];
        exp_t ex;
        h = he.size(); T = (tgt + sk) * 6 + d + 40;
        words = 0; errs = 0; any = 0; fidx = 0; fxor = '0; skc = 0; dec_t = -1;
        stop_t = (ab_t > 0) ? ab_t : rst_t;
        pe = new[T]; pd = new[T]; pev = new[T]; pdv = new[T];
        for (int t = 0; t < T; t++) begin
            pe[t]  = {$urandom, $urandom};
            pev[t] = ($urandom_range(9) != 0);
            pdv[t] = ($urandom_range(99) < vpct);
        end
        chk_ph = (sk == 0);
        for (int t = 0; t < T; t++) begin
            word_t ed, x;
            bit edv;
            int a;
            a = h + t - d;
            if (d == 0)      begin ed = pe[t];     edv = pev[t];     end
            else if (a < 0)  begin ed = '0;        edv = 1'b0;       end
            else if (a < h)  begin ed = he[a];     edv = hev[a];     end
            else             begin ed = pe[a - h]; edv = pev[a - h]; end
            pd[t] = ed;
            if (t == 0 || dec_t >= 0 || (stop_t > 0 && t >= stop_t)) continue;
            if (!chk_ph) begin
                if (pdv[t] && edv) begin skc++; if (skc == sk) chk_ph = 1; end
            end else if (words == tgt) begin
                dec_t = t;
            end else if (pdv[t] && edv) begin
                x = inj(mode, words);
                pd[t] = ed ^ x;
                if (x != 0 && !any) begin any = 1; fidx = words; fxor = x; end
                errs += $countones(x);
                words++;
                if (words == tgt || (so && x != 0)) dec_t = t;
            end
        end
        dly = DW'(d); skip = SKIP_W'(sk); target = CNT_W'(tgt); stop = so;
        if (stop_t == 0) begin
            if (dec_t < 0) begin
                n_cmp++; n_fail++;
                $display("FAIL model_budget: got no end within %0d cycles expected an end", T);
                return;
            end
            ex.words = CNT_W'(words); ex.errs = CNT_W'((errs > CMAX) ? CMAX : errs);
            ex.any = any; ex.fidx = CNT_W'(fidx); ex.fxor = fxor;
            ex.done_cyc = cyc + dec_t + 2;
            sb.push_back(ex);
        end
        last = (stop_t > 0) ? stop_t : dec_t + 1;
        for (int t = 0; t <= last; t++) begin
            drive(t == 0, ab_t > 0 && t == ab_t, !(rst_t > 0 && t == rst_t),
                  pd[t], pdv[t], pe[t], pev[t]);
        end
        if (rst_t > 0) begin
            chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_any", err_any, 0);
            chk("rst_err", err_cnt, 0); chk("rst_word", word_cnt, 0);
            chk("rst_fidx", first_idx, 0); chk("rst_fxor", first_xor, 0);
        end
        for (int i = 0; i < 3; i++) drive(0, 0, 1, '0, 0, '0, 0);
        if (ab_t > 0) begin
            chk("abort_busy", busy, 0); chk("abort_done", done, 0);
            chk("abort_word", word_cnt, words);
            chk("abort_err", err_cnt, (errs > CMAX) ? CMAX : errs);
            chk("abort_any", err_any, any); chk("abort_fidx", first_idx, fidx);
            chk("abort_fxor", first_xor, fxor);
        end
    endtask

    initial begin
        dly = '0; skip = '0; target = '0; stop = 0;
        drive(0, 0, 0, '0, 0, '0, 0);
        drive(0, 0, 0, '0, 0, '0, 0);
        chk("reset_busy", busy, 0); chk("reset_done", done, 0); chk("reset_any", err_any, 0);
        chk("reset_err", err_cnt, 0); chk("reset_word", word_cnt, 0);
        chk("reset_fidx", first_idx, 0); chk("reset_fxor", first_xor, 0);
        drive(0, 0, 1, '0, 0, '0, 0);

        run(3, 4, 1000, 0, 100, 0, 0, 0);                 // aligned clean run
        inj_mask.delete();
        inj_mask[10]  = (word_t'(1) << 3) | (word_t'(1) << 40);
        inj_mask[500] = word_t'(1) << 17;
        run(3, 4, 1000, 0, 100, 1, 0, 0);                 // injected errors
        inj_mask.delete();
        inj_mask[7] = word_t'(1) << 63;
        run(3, 4, 100, 1, 100, 1, 0, 0);                  // stop on error
        run(6, 5, 200, 0, 50, 3, 0, 0);                   // valid gaps + skip
        run(2, 0, 70, 0, 100, 2, 0, 0);                   // saturation
        run(4, 3, 0, 0, 100, 0, 0, 0);                    // target 0
        run(0, 0, 0, 0, 100, 0, 0, 0);                    // target 0, bypass, no skip
        run(5, 2, 500, 0, 100, 3, 60, 0);                 // abort mid-CHECK
        run(5, 2, 500, 0, 100, 3, 0, 60);                 // reset mid-run
        run(5, 2, 120, 0, 100, 3, 0, 0);                  // fresh run after reset
        for (int i = 0; i < 6; i++)
            run((i == 0) ? 0 : $urandom_range(DLY_MAX - 1), $urandom_range(10),
                $urandom_range(150, 1), $urandom_range(1), $urandom_range(100, 30), 3, 0, 0);

        for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
        if (sb.size() != 0) begin
            n_cmp++; n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        @(posedge clk); #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/be_ber_checker.md
# be_ber_checker

Synthesizable, parametrised bit-error checker for the DSP back-end decision output. It compares the back-end decision word against an expected-data stream and counts words and bit errors. A programmable alignment delay absorbs the back-end pipeline latency, and a skip window discards pipeline fill. The block sits beside `dsp_be`, so BER runs can be done in silicon without off-chip capture. It generalises the fixed 64-lane, fixed-depth vector comparison with configurable lane count, delay, skip, target length, stop-on-error and first-error capture.

## Interface
- LANES, 64, decision bits per clock.
- DLY_MAX, 32, maximum expected-stream alignment delay in cycles (power of 2, ≥2).
- CNT_W, 40, width of word and error counters.
- SKIP_W, 8, width of the skip-count input.
- i_clk_dig_be  in  1  back-end digital clock; the only clock.
- i_rst_n  in  1  reset, synchronous, active-low.
- i_start  in  1  one-cycle pulse; starts a run from IDLE or DONE.
- i_abort  in  1  returns the FSM to IDLE; counters hold.
- i_stop_on_err  in  1  when 1, the run ends on the first erroneous word.
- i_dly  in  $clog2(DLY_MAX)  expected-stream delay in cycles; 0 means bypass.
- i_skip  in  SKIP_W  number of valid compare words discarded after start.
- i_target  in  CNT_W  number of words to check after the skip.
- i_drx  in  LANES  DUT decision word.
- i_drx_vld  in  1  i_drx valid.
- i_exp  in  LANES  expected word.
- i_exp_vld  in  1  i_exp valid.
- o_busy  out  1  FSM in SKIP or CHECK, or pipeline draining.
- o_done  out  1  level; run complete, all results final.
- o_err_any  out  1  sticky; at least one bit error in the run.
- o_err_cnt  out  CNT_W  total bit errors, saturating.
- o_word_cnt  out  CNT_W  words checked, excluding skipped words.
- o_first_err_idx  out  CNT_W  o_word_cnt value of the first erroneous word.
- o_first_err_xor  out  LANES  XOR pattern of the first erroneous word.

## Operation
- **Expected delay line:** DLY_MAX-entry shift register of {i_exp_vld, i_exp}, advancing every cycle. The tap is selected by i_dly; i_dly=0 uses i_exp directly. The delay line is not cleared by i_start; it is cleared by reset.
- **Compare event:** a cycle with i_drx_vld=1 and delayed exp_vld=1. Any other cycle is ignored.
- **FSM states:**
  - IDLE → SKIP on i_start, or → CHECK if i_skip=0.
  - SKIP: counts compare events; after i_skip of them → CHECK.
  - CHECK: each compare event increments o_word_cnt. → DRAIN when o_word_cnt reaches i_target, or on the first error if i_stop_on_err=1.
  - DRAIN: waits for the popcount pipeline to empty → DONE.
  - DONE → SKIP/CHECK on i_start.
  - Any state → IDLE on i_abort. i_abort has priority over i_start in the same cycle.
- **Start:** i_start clears o_err_cnt, o_word_cnt, o_err_any, o_first_err_idx and o_first_err_xor. i_start is ignored in SKIP, CHECK and DRAIN.
- **i_target=0:** CHECK goes to DRAIN on its first cycle with zero counts; no compare is made.
- **Error path, stage 1:** register xor = i_drx ^ exp_delayed together with a compare flag.
- **Error path, stage 2:** popcount of the xor, result width $clog2(LANES+1), added to o_err_cnt.
- **Saturation:** o_err_cnt clamps at all-ones. o_word_cnt cannot overflow because i_target bounds it.
- **First error:** the first word with xor≠0 latches o_first_err_idx (0-based word index) and o_first_err_xor, and sets o_err_any. Later errors leave these registers unchanged.
- **Reset:** all outputs 0, FSM in IDLE, delay line 0. A reset mid-run discards the run entirely.

## Timing
- A compare event at cycle N updates o_word_cnt at N+1, o_first_err_* and o_err_any at N+2, and o_err_cnt at N+2.
- o_done rises 2 cycles after the final counted compare event, so all counters are final when o_done=1.
- o_busy and o_done are never high together.
- An i_dly change mid-run takes effect on the next cycle. Data already misaligned is counted as-is.
- i_start at cycle S: counters read 0 from S+1. The first compare eligible for skip/check is at S+1.
- Throughput: one compare per cycle, no stalls.

## Test plan
- **Aligned clean run:** LANES=64, i_dly=3, i_skip=4, i_target=1000, DUT stream = expected stream delayed by 3 → o_done, o_word_cnt=1000, o_err_cnt=0, o_err_any=0.
- **Injected errors:** same setup, flip 2 bits in word 10 and 1 bit in word 500 of checked data → o_err_cnt=3, o_first_err_idx=10, o_first_err_xor has exactly those 2 bits set.
- **Stop-on-error:** i_stop_on_err=1, error injected at word 7 → o_done with o_word_cnt=8, o_first_err_idx=7.
- **Valid gaps and skip:** random deassertion of i_drx_vld (50%), i_skip=5 → only words with both valids counted; the first 5 are excluded; the final count equals i_target.
- **Saturation and corner cases:** CNT_W=8, all-ones mismatch (64 errors/word) for 10 words → o_err_cnt=255. With i_target=0 → o_done within 3 cycles, counts 0. i_abort mid-CHECK → IDLE, counters held.
- **Reset mid-run:** assert i_rst_n=0 during CHECK for one cycle → all outputs 0 next cycle. A new i_start then runs correctly with counters starting from 0.
